// File: rtl/cacheline_adaptor_if.sv
// Bundle of cache-side and memory-side signals around the cacheline adaptor.
// The slave view belongs to the adaptor; the master view is the cache plus memory seen from outside.
interface cacheline_adaptor_if #(
  parameter int BURST_WIDTH = 64,
  parameter int BEATS       = 4,
  parameter int ADDR_WIDTH  = 32
);
  localparam int LINE_WIDTH = BURST_WIDTH * BEATS;

  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits one cache-line read/write into a fixed burst of memory beats and reassembles read beats.
// Every output comes straight from a register, so nothing combinational reaches the ports from an input.
module cacheline_adaptor #(
  parameter int BURST_WIDTH = 64,
  parameter int BEATS       = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);
  localparam int LINE_WIDTH = BURST_WIDTH * BEATS;
  localparam int CNT_WIDTH  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_BITS   = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_WIDTH-1:0]  LAST_BEAT  = CNT_WIDTH'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [BURST_WIDTH-1:0] r_beat [BEATS];
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_read;
  logic                   r_write;
  logic                   r_resp;
  logic [BURST_WIDTH-1:0] r_burst;

  logic [ADDR_WIDTH-1:0]  w_aligned;
  logic                   w_last;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic [LINE_WIDTH-1:0]  w_line;

  assign w_aligned = bus.address_i & ALIGN_MASK;
  assign w_last    = (r_cnt == LAST_BEAT);
  assign w_cnt_inc = w_last ? '0 : r_cnt + 1'b1;

  // Beat 0 occupies the least significant slice of the line.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
    assign w_line[gi*BURST_WIDTH +: BURST_WIDTH] = r_beat[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
      r_burst <= '0;
      for (int i = 0; i < BEATS; i++) begin
        r_beat[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.read_i && !bus.write_i) begin
            r_addr  <= w_aligned;
            r_cnt   <= '0;
            r_read  <= 1'b1;
            r_state <= READ;
          end else if (bus.write_i && !bus.read_i) begin
            r_addr  <= w_aligned;
            r_cnt   <= '0;
            r_write <= 1'b1;
            r_burst <= bus.line_i[BURST_WIDTH-1:0];
            for (int i = 0; i < BEATS; i++) begin
              r_beat[i] <= bus.line_i[i*BURST_WIDTH +: BURST_WIDTH];
            end
            r_state <= WRITE;
          end
        end

        READ: begin
          if (bus.resp_i) begin
            r_beat[r_cnt] <= bus.burst_i;
            r_cnt         <= w_cnt_inc;
            if (w_last) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        WRITE: begin
          // Preload the next beat so burst_o is valid the cycle after each acceptance.
          if (bus.resp_i) begin
            r_cnt   <= w_cnt_inc;
            r_burst <= r_beat[w_cnt_inc];
            if (w_last) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        DONE: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.line_o    = w_line;
  assign bus.resp_o    = r_resp;
  assign bus.burst_o   = r_burst;
  assign bus.address_o = r_addr;
  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: expected lines/beats are queued at stimulus time
// and compared when the adaptor presents them.
module tb_cacheline_adaptor;
  localparam int BW = 64;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int LW = BW * NB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.BURST_WIDTH(BW), .BEATS(NB), .ADDR_WIDTH(AW)) bus ();

  cacheline_adaptor #(.BURST_WIDTH(BW), .BEATS(NB), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [LW-1:0] line_q [$];
  logic [BW-1:0] beat_q [$];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [2:0] ctl();
    return {bus.read_o, bus.write_o, bus.resp_o};
  endfunction

  task automatic wait_done(input string tag);
    int lat = 0;
    while (bus.resp_o !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_resp_lat"}, lat, 0);
    check({tag, "_done_ctl"}, ctl(), 3'b001);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of the IDLE cycle after DONE.
  task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [LW-1:0] data,
                         input logic [15:0] pat, input int plen);
    int beat = 0;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b0;
    bus.address_i = addr;
    line_q.push_back(data);
    tick();
    bus.address_i = ~addr;
    for (int k = 0; k < plen; k++) begin
      check({tag, "_ctl"}, ctl(), 3'b100);
      check({tag, "_addr"}, bus.address_o, align(addr));
      bus.resp_i = pat[k];
      if (pat[k]) begin
        bus.burst_i = data[beat*BW +: BW];
        beat++;
      end else begin
        bus.burst_i = {$urandom, $urandom};
      end
      tick();
    end
    bus.resp_i = 1'b0;
    wait_done(tag);
    if (line_q.size() > 0) check({tag, "_line"}, bus.line_o, line_q.pop_front());
    else check({tag, "_line_q_empty"}, 1, 0);
    bus.read_i = 1'b0;
    tick();
    check({tag, "_idle_ctl"}, ctl(), 3'b000);
    $display("read  %s addr=%h line=%h", tag, addr, data);
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [LW-1:0] data,
                          input logic [15:0] pat, input int plen);
    bus.write_i   = 1'b1;
    bus.read_i    = 1'b0;
    bus.address_i = addr;
    bus.line_i    = data;
    for (int i = 0; i < NB; i++) beat_q.push_back(data[i*BW +: BW]);
    tick();
    bus.line_i    = ~data;
    bus.address_i = ~addr;
    for (int k = 0; k < plen; k++) begin
      check({tag, "_ctl"}, ctl(), 3'b010);
      check({tag, "_addr"}, bus.address_o, align(addr));
      if (beat_q.size() > 0) check({tag, "_burst"}, bus.burst_o, beat_q[0]);
      else check({tag, "_beat_q_empty"}, 1, 0);
      bus.resp_i = pat[k];
      if (pat[k] && beat_q.size() > 0) void'(beat_q.pop_front());
      tick();
    end
    bus.resp_i = 1'b0;
    wait_done(tag);
    check({tag, "_beats_left"}, beat_q.size(), 0);
    beat_q.delete();
    bus.write_i = 1'b0;
    tick();
    check({tag, "_idle_ctl"}, ctl(), 3'b000);
    $display("write %s addr=%h line=%h", tag, addr, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] d_rd1, d_wr1, d_rd2, d_wr2, d_rd3, d_wr3, d_rd4;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ctl", ctl(), 3'b000);
    check("rst_line", bus.line_o, '0);
    check("rst_burst", bus.burst_o, '0);
    check("rst_addr", bus.address_o, '0);
    rst = 1'b0;
    tick();
    $display("reset done");

    d_rd1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read("rd_nostall", 32'h0000_1234, d_rd1, 16'h000F, 4);
    check("rd_nostall_addr_abs", bus.address_o, 32'h0000_1220);

    d_wr1 = {64'hD3D3_0303_3333_D3D3, 64'hD2D2_0202_2222_D2D2,
             64'hD1D1_0101_1111_D1D1, 64'hD0D0_0000_0000_D0D0};
    do_write("wr_nostall", 32'hABCD_EF7F, d_wr1, 16'h000F, 4);

    d_rd2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read("rd_stall", 32'h8000_0040, d_rd2, 16'h0059, 7);

    d_wr2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write("wr_stall", 32'h0000_0FE1, d_wr2, 16'h0036, 6);

    bus.read_i = 1'b1; bus.write_i = 1'b1; bus.address_i = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      bus.resp_i = (k != 1);
      tick();
      check("illegal_ctl", ctl(), 3'b000);
    end
    bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.resp_i = 1'b1;
    tick();
    check("spurious_resp_ctl", ctl(), 3'b000);
    bus.resp_i = 1'b0;
    tick();
    $display("illegal/spurious idle inputs done");

    d_wr3 = {64'hCCCC_0000_0000_0003, 64'hCCCC_0000_0000_0002,
             64'hCCCC_0000_0000_0001, 64'hCCCC_0000_0000_0000};
    bus.write_i = 1'b1; bus.address_i = 32'h0000_2000; bus.line_i = d_wr3;
    tick();
    bus.resp_i = 1'b1;
    tick();
    tick();
    bus.resp_i = 1'b0;
    check("rstmid_burst2", bus.burst_o, d_wr3[2*BW +: BW]);
    #2 rst = 1'b1;
    bus.write_i = 1'b0;
    #1;
    check("rstmid_ctl", ctl(), 3'b000);
    check("rstmid_burst", bus.burst_o, '0);
    check("rstmid_addr", bus.address_o, '0);
    check("rstmid_line", bus.line_o, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    $display("reset mid-write done");
    d_rd3 = {64'h0BAD_0000_0000_0004, 64'h0BAD_0000_0000_0003,
             64'h0BAD_0000_0000_0002, 64'h0BAD_0000_0000_0001};
    do_read("rd_after_rst", 32'h0000_3010, d_rd3, 16'h000F, 4);

    d_wr4_init: begin
      d_wr2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    do_write("b2b_wr", 32'h0001_0000, d_wr2, 16'h000F, 4);
    d_rd4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read("b2b_rd", 32'h0001_0020, d_rd4, 16'h001D, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache controller, on the physical-memory side.
- Converts one cache-line request (read or write) from the cache into a fixed burst of narrower memory beats, and converts the returned beats back into a full line.
- Cache-side signals carry the controller's pmem_read/pmem_write/pmem_resp handshake. Memory-side signals drive the burst DRAM model.

Parameters:
- BURST_WIDTH, 64, width in bits of one memory beat.
- BEATS, 4, beats per cache line; the beat counter is clog2(BEATS) bits.
- LINE_WIDTH, BURST_WIDTH*BEATS (256), cache line width in bits; derived, not overridden.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- line_i  in  LINE_WIDTH  write data from the cache.
- line_o  out  LINE_WIDTH  assembled read line to the cache.
- address_i  in  ADDR_WIDTH  line address from the cache.
- read_i  in  1  line read request (pmem_read).
- write_i  in  1  line write request (pmem_write).
- resp_o  out  1  line transfer complete (pmem_resp).
- burst_i  in  BURST_WIDTH  read beat from memory.
- burst_o  out  BURST_WIDTH  write beat to memory.
- address_o  out  ADDR_WIDTH  line-aligned address to memory.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  memory beat valid/accepted.

Behaviour:
- Reset (async, any state):
  - State = IDLE; beat counter = 0; line buffer = 0; latched address = 0.
  - read_o = write_o = resp_o = 0; line_o = 0; burst_o = 0; address_o = 0.
- States: IDLE, READ, WRITE, DONE. All outputs are decoded from registered state, counter and buffers; no input-to-output combinational path.
- IDLE:
  - read_i=1 and write_i=0: latch address_i with low log2(LINE_WIDTH/8) bits (5) zeroed; counter=0; go to READ.
  - write_i=1 and read_i=0: latch aligned address and line_i into the buffer; counter=0; go to WRITE.
  - Both or neither asserted: stay in IDLE (no-op).
  - resp_i is ignored in IDLE.
- READ:
  - read_o=1 throughout; address_o = latched address.
  - On each edge with resp_i=1: buffer[counter*BURST_WIDTH +: BURST_WIDTH] <= burst_i; counter++.
  - Cycles with resp_i=0 are stalls; they neither advance the counter nor write the buffer.
  - When the beat with counter==BEATS-1 is taken: go to DONE; counter wraps to 0.
- WRITE:
  - write_o=1 throughout; burst_o = buffer[counter*BURST_WIDTH +: BURST_WIDTH].
  - Beat 0 is presented in the first WRITE cycle; each resp_i=1 edge advances to the next beat.
  - The last accepted beat goes to DONE, with the same stall and wrap rules as READ.
- DONE:
  - Lasts exactly one cycle: resp_o=1, read_o=write_o=0, line_o = buffer. Then go to IDLE.
  - The request is not re-sampled in DONE. The cache drops its request in the cycle after it sees resp_o.
- line_o:
  - Holds the buffer contents continuously.
  - Its contents are defined only while resp_o=1 after a READ.
- Latency:
  - The edge that accepts the request enters READ/WRITE.
  - With resp_i high on 4 consecutive cycles, resp_o is high in the 5th cycle after the accepting edge.
  - Each stall cycle adds one cycle.
- Request inputs (read_i, write_i, address_i, line_i) changing during READ/WRITE are ignored; only latched copies are used.
- Beat order: little-endian, beat 0 = line bits [BURST_WIDTH-1:0].

Test Plan:
- Read, no stalls: read_i=1, address_i=0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i cycles -> address_o=0x0000_1220; read_o high for 4 cycles; resp_o high for exactly 1 cycle; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, no stalls: write_i=1, line_i = {D3,D2,D1,D0} -> write_o high; burst_o = D0, D1, D2, D3 on successive resp_i edges; then resp_o pulses once; write_o low during DONE.
- Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; resp_o in the cycle after the 7th pattern cycle; no buffer writes on stall cycles.
- Illegal and spurious inputs: read_i=write_i=1 in IDLE for 3 cycles, and resp_i pulsed while in IDLE -> state stays IDLE; read_o=write_o=resp_o=0.
- Reset mid-operation: assert rst asynchronously (between clock edges) after 2 write beats -> all outputs 0 immediately, without waiting for a clock edge. A following read transfers all 4 beats starting from beat 0.
- Back-to-back: a write followed by a read issued the cycle after DONE -> the read is accepted from IDLE, the buffer is overwritten, and line_o matches the new read data.
